// File: rtl/gpio_bank_ctrl.sv
// Banked bidirectional GPIO controller with masked register writes, two-flop
// input synchronisers, per-pin rise/fall capture into sticky status and a combined irq.
module gpio_bank_ctrl #(
  parameter int         NUM_BANKS = 4,
  parameter int         WIDTH     = 16,
  parameter logic [6:0] OE_BASE   = 7'd64,
  parameter logic [6:0] OUT_BASE  = 7'd72,
  parameter logic [6:0] RISE_BASE = 7'd80,
  parameter logic [6:0] FALL_BASE = 7'd88,
  parameter logic [6:0] CLR_BASE  = 7'd96
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [6:0]                 serial_addr,
  input  logic [31:0]                serial_data,
  input  logic                       serial_strobe,
  inout  wire  [NUM_BANKS*WIDTH-1:0] io,
  output logic [NUM_BANKS*WIDTH-1:0] pin_in,
  output logic [NUM_BANKS*WIDTH-1:0] edge_status,
  output logic                       irq
);

  localparam int N = NUM_BANKS * WIDTH;

  logic [N-1:0] oe_q, oe_d;
  logic [N-1:0] out_q, out_d;
  logic [N-1:0] rise_en_q, rise_en_d;
  logic [N-1:0] fall_en_q, fall_en_d;
  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] status_q, status_d;
  logic         irq_q, irq_d;
  logic [1:0]   arm_cnt_q, arm_cnt_d;

  logic [N-1:0]     clr, rise, fall;
  logic             armed;
  logic [WIDTH-1:0] wr_mask, wr_val;

  assign wr_mask = serial_data[16 +: WIDTH];
  assign wr_val  = serial_data[0 +: WIDTH];

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur,
                                             input logic [WIDTH-1:0] m,
                                             input logic [WIDTH-1:0] v);
    return (cur & ~m) | (v & m);
  endfunction

  // Register decode: only addresses that land on an existing bank have any effect.
  always_comb begin
    oe_d      = oe_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (serial_strobe) begin
        if (serial_addr == OE_BASE + 7'(b))
          oe_d[b*WIDTH +: WIDTH] = merge(oe_q[b*WIDTH +: WIDTH], wr_mask, wr_val);
        if (serial_addr == OUT_BASE + 7'(b))
          out_d[b*WIDTH +: WIDTH] = merge(out_q[b*WIDTH +: WIDTH], wr_mask, wr_val);
        if (serial_addr == RISE_BASE + 7'(b))
          rise_en_d[b*WIDTH +: WIDTH] = merge(rise_en_q[b*WIDTH +: WIDTH], wr_mask, wr_val);
        if (serial_addr == FALL_BASE + 7'(b))
          fall_en_d[b*WIDTH +: WIDTH] = merge(fall_en_q[b*WIDTH +: WIDTH], wr_mask, wr_val);
        if (serial_addr == CLR_BASE + 7'(b))
          clr[b*WIDTH +: WIDTH] = wr_val & wr_mask;
      end
    end
  end

  // Edges are ignored until the sync chain has flushed its reset contents.
  always_comb begin
    s1_d      = io;
    s2_d      = s1_q;
    prev_d    = s2_q;
    armed     = (arm_cnt_q == 2'd3);
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
    rise      = s2_q & ~prev_q & rise_en_q & {N{armed}};
    fall      = ~s2_q & prev_q & fall_en_q & {N{armed}};
    status_d  = (status_q & ~clr) | rise | fall;
    irq_d     = |status_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      oe_q      <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      arm_cnt_q <= 2'd0;
    end else begin
      oe_q      <= oe_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      prev_q    <= prev_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_pad
    assign io[gi] = oe_q[gi] ? out_q[gi] : 1'bz;
  end

  assign pin_in      = s2_q;
  assign edge_status = status_q;
  assign irq         = irq_q;

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
Parametrised bidirectional GPIO controller for the daughterboard I/O banks, configured over the standard serial register bus. Each pin has a masked-write output-enable bit, a masked-write output-data bit, a synchronised input readback, and rising/falling edge capture. Captured edges set sticky status bits and raise a combined interrupt. The block sits between the serial register decoder and the FPGA pad ring.

Parameters:
NUM_BANKS, 4, number of I/O banks (1..8)
WIDTH, 16, pins per bank (1..16)
OE_BASE, 7'd64, serial address of bank 0 output-enable register; bank b at OE_BASE+b
OUT_BASE, 7'd72, bank b output-data register at OUT_BASE+b
RISE_BASE, 7'd80, bank b rising-edge enable at RISE_BASE+b
FALL_BASE, 7'd88, bank b falling-edge enable at FALL_BASE+b
CLR_BASE, 7'd96, bank b status write-1-to-clear at CLR_BASE+b

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous reset, active-low
serial_addr  input  7  register address
serial_data  input  32  write data; [31:16] mask, [15:0] value
serial_strobe  input  1  one-cycle write qualifier
io  inout  NUM_BANKS*WIDTH  pads; bank b occupies [b*WIDTH +: WIDTH]
pin_in  output  NUM_BANKS*WIDTH  synchronised pad values
edge_status  output  NUM_BANKS*WIDTH  sticky edge flags
irq  output  1  OR of all edge_status bits, registered

Behaviour:
- Reset (reset_n low at a clock edge): oe, out, rise_en, fall_en, edge_status, sync stages, pin_in and irq all go to 0. arm_cnt is set to 0.
- Pad drive: io[i] = oe[i] ? out[i] : Z, purely combinational from the registers. A pad changes in the cycle after the strobe edge.
- Masked write to OE/OUT/RISE/FALL of bank b when serial_strobe=1 and the address matches: reg <= (reg & ~m) | (v & m).
  - m = serial_data[16 +: WIDTH]; v = serial_data[0 +: WIDTH].
  - Data bits above WIDTH are ignored.
- CLR write: edge_status[bank b] <= edge_status & ~(v & m).
- Unmatched addresses, and bank indices >= NUM_BANKS, are ignored with no side effect.
- Input path per pin: s1 <= io, then s2 <= s1. pin_in = s2, i.e. a pad change reaches pin_in 2 clocks later. prev <= s2.
- Edge detect:
  - rise = s2 & ~prev & rise_en.
  - fall = ~s2 & prev & fall_en.
  - Gated by armed.
- Arming:
  - arm_cnt is a 2-bit saturating counter incrementing each cycle after reset; armed = (arm_cnt==3).
  - This suppresses false edges from the reset values of the sync flops.
  - Pads high at reset release produce no flag.
- Status: edge_status[i] <= (edge_status[i] & ~clr[i]) | rise[i] | fall[i]. A simultaneous set and clear on the same bit leaves the bit set.
- irq <= |edge_status (the next-state value), so irq asserts the same cycle edge_status is visible. Latency from pad edge to irq is 3 clocks.
- Pins with oe=1 still feed the input path, so driven outputs loop back to pin_in and can generate edges.
- Reset mid-operation: all state clears at that edge regardless of serial_strobe; a write in the same cycle is discarded.
- Writing an enable register does not clear existing status. Disabling an enable stops new flags only.

Test Plan:
- Reset, then drive nothing externally -> io all Z, pin_in=0, edge_status=0, irq=0. Pull a pad high at reset release -> no flag.
- Write OE_BASE+1 data 0x00FF_00A5, then OUT_BASE+1 data 0x0F0F_FFFF -> bank 1 oe=0x00A5; out=0x0F0F. io[16+:16] drives bit0=1, bit2=1, bit5=0, bit7=0; other bits Z.
- Second masked write OE_BASE+1 data 0x0001_0000 -> only bit0 cleared, oe=0x00A4; other bits retained.
- Set RISE_BASE+0=0xFFFF_0008 and drive pad 3 low->high -> pin_in[3]=1 after 2 clocks, edge_status[3]=1 and irq=1 after 3 clocks. A falling edge on pad 3 with fall_en=0 -> no change.
- Write CLR_BASE+0 0x0008_0008 in the same cycle a new rising edge on pad 3 is detected -> edge_status[3] stays 1. A later clear with no edge -> 0, irq drops the next cycle.
- Write to OE_BASE+NUM_BANKS and to an unmapped address 7'd5 -> no register change. Assert reset_n=0 during a strobe -> all registers 0, write lost.
